// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard frame receiver: one bit per clk edge, start/odd-parity/stop
// checking, 8-bit scan code presented with a single-cycle done strobe.
module ps2_keyboard_decoder #(
  parameter bit CHECK_PARITY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,  // synchronous, active-high despite the name
  input  logic       data,
  output logic [7:0] code,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        parity_ok;
  logic        load_code;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    load_code  = 1'b0;
    unique case (state)
      IDLE:    if (!data) state_next = DATA;
      DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
      PARITY:  state_next = STOP;
      STOP: begin
        state_next = IDLE;
        load_code  = data && (parity_ok || !CHECK_PARITY);
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      parity_ok <= 1'b0;
      code      <= 8'h00;
      done      <= 1'b0;
    end else begin
      done <= load_code;
      if (load_code) code <= shift;
      unique case (state)
        IDLE: if (!data) bit_cnt <= 3'd0;
        DATA: begin
          // LSB arrives first; shifting in from the top leaves it in [0].
          shift   <= {data, shift[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        PARITY:  parity_ok <= ^{shift, data};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Self-checking bench: two decoders (parity checked / ignored) on one data line,
// compared each cycle against a frame-level reference model.
module tb_ps2_keyboard_decoder;

  logic       clk;
  logic       rst_n;
  logic       data;
  logic [7:0] code_p, code_n;
  logic       done_p, done_n;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] model_p, model_n;

  ps2_keyboard_decoder #(.CHECK_PARITY(1'b1)) dut_p (
    .clk(clk), .rst_n(rst_n), .data(data), .code(code_p), .done(done_p)
  );

  ps2_keyboard_decoder #(.CHECK_PARITY(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .data(data), .code(code_n), .done(done_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_done_p, input logic exp_done_n);
    check({tag, " done_p"}, {7'd0, done_p}, {7'd0, exp_done_p});
    check({tag, " code_p"}, code_p, model_p);
    check({tag, " done_n"}, {7'd0, done_n}, {7'd0, exp_done_n});
    check({tag, " code_n"}, code_n, model_n);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      data  = 1'b0;
      @(posedge clk);
      #1;
      model_p = 8'h00;
      model_n = 8'h00;
      check_all("reset", 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    data  = 1'b1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      data = 1'b1;
      @(posedge clk);
      #1;
      check_all("idle", 1'b0, 1'b0);
    end
  endtask

  // Sends the first nbits of a frame; a complete frame is nbits = 11.
  task automatic send_frame(input string tag, input logic [7:0] byte_val,
                            input logic par_good, input logic stop_bit,
                            input int nbits);
    logic [10:0] bits;
    logic        par;
    logic        valid_p, valid_n;
    par     = par_good ? ~(^byte_val) : (^byte_val);
    bits    = {stop_bit, par, byte_val, 1'b0};
    valid_p = stop_bit && par_good;
    valid_n = stop_bit;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      data = bits[i];
      @(posedge clk);
      #1;
      if (i == 10) begin
        if (valid_p) model_p = byte_val;
        if (valid_n) model_n = byte_val;
        check_all(tag, valid_p, valid_n);
      end else begin
        check_all(tag, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic       rpar, rstop;
    rst_n   = 1'b0;
    data    = 1'b1;
    model_p = 8'h00;
    model_n = 8'h00;

    do_reset(2);
    idle(2);

    send_frame("aa", 8'hAA, 1'b1, 1'b1, 11);
    idle(1);

    send_frame("b2b_1c", 8'h1C, 1'b1, 1'b1, 11);
    send_frame("b2b_f0", 8'hF0, 1'b1, 1'b1, 11);
    idle(2);

    send_frame("badpar", 8'hAA, 1'b0, 1'b1, 11);
    idle(1);

    send_frame("framing", 8'h55, 1'b1, 1'b0, 11);
    idle(1);
    send_frame("after_framing", 8'h12, 1'b1, 1'b1, 11);
    idle(1);

    // Start bit plus four data bits of 0xFF, then reset mid-frame.
    send_frame("partial", 8'hFF, 1'b1, 1'b1, 5);
    do_reset(1);
    idle(1);
    send_frame("after_reset", 8'h3A, 1'b1, 1'b1, 11);
    idle(1);

    for (int n = 0; n < 40; n++) begin
      rb    = 8'($urandom_range(0, 255));
      rpar  = ($urandom_range(0, 3) != 0);
      rstop = ($urandom_range(0, 7) != 0);
      send_frame("rand", rb, rpar, rstop, 11);
      idle($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
